onchip_mem_loader: RTL

ONCHIP_MEM_LOADER -- requirements
Module: onchip_mem_loader

---
 rtl/onchip_mem_loader.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/onchip_mem_loader.sv
// Byte-stream to 32-bit on-chip memory loader: packs bytes little-endian and writes words from BASE_WORD upward.
// Optional running checksum of written words is built only when LOADER_CHECKSUM_EN is defined.
module onchip_mem_loader #(
    parameter int DEPTH_WORDS = 5120,
    parameter int BASE_WORD   = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [12:0] len_words,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        abort,
    output logic [12:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic        mem_clken,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        aborted,
    output logic [31:0] checksum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [31:0] BASE_U   = BASE_WORD;
    localparam logic [31:0] DEPTH_U  = DEPTH_WORDS;
    localparam logic [12:0] BASE_PTR = 13'(BASE_WORD);
    localparam logic [12:0] LAST_PTR = 13'(DEPTH_WORDS - 1);

    logic [1:0]  state_q, state_d;
    logic [12:0] ptr_q, ptr_d;
    logic [12:0] cnt_q, cnt_d;
    logic [12:0] len_q, len_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  be_q, be_d;
    logic        pend_q, pend_d;
    logic        aborted_q, aborted_d;
    logic        error_q, error_d;

    logic        xfer;
    logic [2:0]  lanes_eff;
    logic [3:0]  lane_mask;
    logic        too_long;

    assign too_long  = (BASE_U + 32'(len_words)) > DEPTH_U;
    assign xfer      = (state_q == S_FILL) && in_valid;
    // Lanes filled once this cycle's byte (if any) is counted; abort acts on this value.
    assign lanes_eff = {1'b0, lane_q} + {2'b00, xfer};
    assign lane_mask = 4'((5'd1 << lanes_eff) - 5'd1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        lane_d    = lane_q;
        data_d    = data_q;
        be_d      = be_q;
        pend_d    = pend_q;
        aborted_d = aborted_q;
        error_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (too_long) begin
                        error_d = 1'b1;
                    end else if (len_words == 13'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_FILL;
                        aborted_d = 1'b0;
                        ptr_d     = BASE_PTR;
                        cnt_d     = 13'd0;
                        len_d     = len_words;
                        lane_d    = 2'd0;
                        data_d    = 32'd0;
                        pend_d    = 1'b0;
                    end
                end
            end
            S_FILL: begin
                if (xfer) begin
                    data_d[{lane_q, 3'b000} +: 8] = in_data;
                    lane_d = lane_q + 2'd1;
                end
                if (lanes_eff == 3'd4) begin
                    state_d = S_WRITE;
                    be_d    = 4'hF;
                    pend_d  = abort;
                end
                if (abort) begin
                    aborted_d = 1'b1;
                    if (lanes_eff == 3'd0) begin
                        state_d = S_DONE;
                    end else if (lanes_eff != 3'd4) begin
                        state_d = S_WRITE;
                        be_d    = lane_mask;
                        pend_d  = 1'b1;
                        lane_d  = 2'd0;
                    end
                end
            end
            S_WRITE: begin
                cnt_d  = cnt_q + 13'd1;
                be_d   = 4'h0;
                data_d = 32'd0;
                pend_d = 1'b0;
                // Saturate so a load ending on the last word leaves the pointer in range.
                if (ptr_q != LAST_PTR) begin
                    ptr_d = ptr_q + 13'd1;
                end
                if (pend_q || (cnt_d == len_q)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= BASE_PTR;
            cnt_q     <= 13'd0;
            len_q     <= 13'd0;
            lane_q    <= 2'd0;
            data_q    <= 32'd0;
            be_q      <= 4'h0;
            pend_q    <= 1'b0;
            aborted_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            lane_q    <= lane_d;
            data_q    <= data_d;
            be_q      <= be_d;
            pend_q    <= pend_d;
            aborted_q <= aborted_d;
            error_q   <= error_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if ((state_q == S_IDLE) && start && !too_long && (len_words != 13'd0)) begin
            sum_d = 32'd0;
        end else if (state_q == S_WRITE) begin
            sum_d = sum_q + data_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 32'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'd0;
`endif

    assign in_ready       = (state_q == S_FILL);
    assign mem_address    = ptr_q;
    assign mem_byteenable = be_q;
    assign mem_chipselect = (state_q == S_WRITE);
    assign mem_write      = (state_q == S_WRITE);
    assign mem_writedata  = data_q;
    assign mem_clken      = 1'b1;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign error          = error_q;
    assign aborted        = aborted_q;

endmodule
